// File: rtl/vrf_read_pkg.sv
// vrf_read_pkg: shared types and widths for the VRF read sequencer slice.
//   seq_state_e  - sequencer FSM states
//   CNT_WIDTH    - word-count width (covers 0..MAX_WORDS)
//   VS_WIDTH / RS_WIDTH / II_WIDTH - source register, readSource and
//                  instructionIndex field widths
//   MAX_WORDS    - 16 groups x 2 offsets; larger counts are clamped to this
package vrf_read_pkg;

    localparam int unsigned CNT_WIDTH = 6;
    localparam int unsigned VS_WIDTH  = 5;
    localparam int unsigned RS_WIDTH  = 4;
    localparam int unsigned II_WIDTH  = 3;
    localparam int unsigned MAX_WORDS = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/vrf_read_sequencer_if.sv
// vrf_read_sequencer_if: command, read-request, read-response and consumer
// buses of the VRF read sequencer.
//   master modport - the sequencer (accepts cmd, issues req, forwards rsp to out)
//   slave  modport - the environment (command source, read pipe, consumer)
interface vrf_read_sequencer_if #(
    parameter int unsigned CNT_W = vrf_read_pkg::CNT_WIDTH
);
    import vrf_read_pkg::*;

    // command
    logic                cmd_valid;
    logic                cmd_ready;
    logic [VS_WIDTH-1:0] cmd_vs;
    logic [CNT_W-1:0]    cmd_count;
    logic [RS_WIDTH-1:0] cmd_readSource;
    logic [II_WIDTH-1:0] cmd_instructionIndex;

    // read-pipe enqueue
    logic                req_valid;
    logic                req_ready;
    logic [VS_WIDTH-1:0] req_vs;
    logic                req_offset;
    logic [3:0]          req_groupIndex;
    logic [RS_WIDTH-1:0] req_readSource;
    logic [II_WIDTH-1:0] req_instructionIndex;

    // read-pipe dequeue
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_data;

    // consumer
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_data;
    logic                out_last;

    modport master (
        input  cmd_valid, cmd_vs, cmd_count, cmd_readSource, cmd_instructionIndex,
        output cmd_ready,
        output req_valid, req_vs, req_offset, req_groupIndex, req_readSource,
               req_instructionIndex,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        output cmd_valid, cmd_vs, cmd_count, cmd_readSource, cmd_instructionIndex,
        input  cmd_ready,
        input  req_valid, req_vs, req_offset, req_groupIndex, req_readSource,
               req_instructionIndex,
        output req_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        input  out_valid, out_data, out_last,
        output out_ready
    );

endinterface

// File: rtl/vrf_read_credit_counter.sv
// vrf_read_credit_counter: tracks free slots in the downstream read-data queue.
//   clock, reset - synchronous active-high reset loads MAX_OUTSTANDING
//   take         - a read was issued (consumes one credit)
//   give         - a response was consumed (returns one credit)
//   credits      - current credit count, 0..MAX_OUTSTANDING
//   avail        - credits > 0
module vrf_read_credit_counter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 take,
    input  logic                                 give,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] credits,
    output logic                                 avail
);

    localparam int unsigned CRED_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CRED_W-1:0] credits_q, credits_d;

    // take and give together cancel; saturate at both ends
    always_comb begin
        credits_d = credits_q;
        if (take && !give && credits_q != '0) begin
            credits_d = credits_q - 1'b1;
        end else if (give && !take && credits_q != CRED_W'(MAX_OUTSTANDING)) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            credits_q <= CRED_W'(MAX_OUTSTANDING);
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits = credits_q;
    assign avail   = (credits_q != '0);

endmodule

// File: rtl/vrf_read_sequencer.sv
// vrf_read_sequencer: turns one read command (source register + word count)
// into a stream of per-word read requests to the VRF read pipe, limited by
// the downstream queue credits, and forwards the returning data to the
// consumer with a last marker and a one-cycle done pulse.
//   clock, reset - synchronous active-high reset
//   bus          - vrf_read_sequencer_if.master (cmd / req / rsp / out)
//   done         - single-cycle completion pulse
//   perf_stall   - ISSUE stall-cycle counter, present only when
//                  VRF_READ_SEQ_PERF_EN is defined
module vrf_read_sequencer
    import vrf_read_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = vrf_read_pkg::CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    vrf_read_sequencer_if.master  bus,
    output logic                  done
`ifdef VRF_READ_SEQ_PERF_EN
    ,
    output logic [15:0]           perf_stall
`endif
);

    localparam int unsigned      CRED_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    issue_idx_q, issue_idx_d;
    logic [CNT_W-1:0]    recv_idx_q, recv_idx_d;
    logic [VS_WIDTH-1:0] vs_q, vs_d;
    logic [RS_WIDTH-1:0] rs_q, rs_d;
    logic [II_WIDTH-1:0] ii_q, ii_d;

    logic [CRED_W-1:0]   credits;
    logic                avail;
    logic                req_fire;
    logic                out_fire;
    logic                out_last_c;
    logic [CNT_W-1:0]    cmd_count_clamped;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        issue_idx_d = issue_idx_q;
        recv_idx_d  = recv_idx_q;
        vs_d        = vs_q;
        rs_d        = rs_q;
        ii_d        = ii_q;

        bus.cmd_ready            = 1'b0;
        bus.req_valid            = 1'b0;
        bus.req_vs               = '0;
        bus.req_offset           = 1'b0;
        bus.req_groupIndex       = '0;
        bus.req_readSource       = '0;
        bus.req_instructionIndex = '0;
        bus.rsp_ready            = 1'b0;
        bus.out_valid            = 1'b0;
        bus.out_data             = '0;
        bus.out_last             = 1'b0;
        done                     = 1'b0;
        req_fire                 = 1'b0;
        out_fire                 = 1'b0;
        out_last_c               = 1'b0;

        cmd_count_clamped = (bus.cmd_count > MAX_CNT) ? MAX_CNT : bus.cmd_count;

        unique case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    count_d     = cmd_count_clamped;
                    vs_d        = bus.cmd_vs;
                    rs_d        = bus.cmd_readSource;
                    ii_d        = bus.cmd_instructionIndex;
                    issue_idx_d = '0;
                    recv_idx_d  = '0;
                    state_d     = (cmd_count_clamped == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // fields derive only from held state, so they stay stable under backpressure
                bus.req_valid            = avail;
                bus.req_vs               = vs_q;
                bus.req_offset           = issue_idx_q[0];
                bus.req_groupIndex       = issue_idx_q[4:1];
                bus.req_readSource       = rs_q;
                bus.req_instructionIndex = ii_q;
                req_fire                 = avail && bus.req_ready;
                if (req_fire) begin
                    issue_idx_d = issue_idx_q + 1'b1;
                    if (issue_idx_q == count_q - 1'b1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // response path is a combinational pass-through while a command is live
        if (state_q == S_ISSUE || state_q == S_DRAIN) begin
            out_last_c    = (recv_idx_q == count_q - 1'b1);
            bus.out_valid = bus.rsp_valid;
            bus.out_data  = bus.rsp_data;
            bus.out_last  = out_last_c;
            bus.rsp_ready = bus.out_ready;
            out_fire      = bus.rsp_valid && bus.out_ready;
            if (out_fire) begin
                recv_idx_d = recv_idx_q + 1'b1;
                if (out_last_c) begin
                    state_d = S_DONE;
                end
            end
        end

        // outputs are forced to their idle values for the whole reset cycle
        if (reset) begin
            bus.cmd_ready            = 1'b1;
            bus.req_valid            = 1'b0;
            bus.req_vs               = '0;
            bus.req_offset           = 1'b0;
            bus.req_groupIndex       = '0;
            bus.req_readSource       = '0;
            bus.req_instructionIndex = '0;
            bus.rsp_ready            = 1'b0;
            bus.out_valid            = 1'b0;
            bus.out_data             = '0;
            bus.out_last             = 1'b0;
            done                     = 1'b0;
            req_fire                 = 1'b0;
            out_fire                 = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            issue_idx_q <= '0;
            recv_idx_q  <= '0;
            vs_q        <= '0;
            rs_q        <= '0;
            ii_q        <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            issue_idx_q <= issue_idx_d;
            recv_idx_q  <= recv_idx_d;
            vs_q        <= vs_d;
            rs_q        <= rs_d;
            ii_q        <= ii_d;
        end
    end

    vrf_read_credit_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credits (
        .clock   (clock),
        .reset   (reset),
        .take    (req_fire),
        .give    (out_fire),
        .credits (credits),
        .avail   (avail)
    );

`ifdef VRF_READ_SEQ_PERF_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic        stall;

    always_comb begin
        stall        = (state_q == S_ISSUE) && ((avail && !bus.req_ready) || !avail);
        perf_stall_d = perf_stall_q;
        if (stall && perf_stall_q != '1) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_vrf_read_sequencer.sv
// tb_vrf_read_sequencer: self-checking bench for vrf_read_sequencer.
// A table of commands with backpressure modes drives the main flow; a
// request/response scoreboard predicts every req and out beat; directed
// sequences cover credit exhaustion, same-cycle credit return, reset
// mid-command and (with VRF_READ_SEQ_PERF_EN) the stall counter.
module tb_vrf_read_sequencer;
    import vrf_read_pkg::*;

    localparam int unsigned MAXO = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic done;

    always #5 clock = ~clock;

    vrf_read_sequencer_if #(.CNT_W(CNT_WIDTH)) bus ();

`ifdef VRF_READ_SEQ_PERF_EN
    logic [15:0] perf_stall;
`endif

    vrf_read_sequencer #(
        .MAX_OUTSTANDING(MAXO),
        .CNT_W(CNT_WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .done  (done)
`ifdef VRF_READ_SEQ_PERF_EN
        ,
        .perf_stall (perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_out_t;

    typedef struct {
        logic [4:0]  vs;
        int unsigned count;
        logic [3:0]  rs;
        logic [2:0]  ii;
        int          rq_mode;   // 0 random, 1 high, 2 low
        int          out_mode;
        int          rsp_mode;  // 0 random, 1 whenever data pending, 2 withheld
        int unsigned exp_reqs;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    vec_t        tbl[9];
    logic [31:0] pipe[$];
    exp_out_t    exp_out[$];

    int unsigned m_count, m_k, cyc_since_cmd;
    int          in_flight;
    logic [4:0]  m_vs;
    logic [3:0]  m_rs;
    logic [2:0]  m_ii;
    int          rq_mode, out_mode, rsp_mode;
    bit          prev_last_fire, prev_req_stall, last_rf, last_of;
    logic [16:0] prev_fields;
    logic [16:0] req_fields;

    assign req_fields = {bus.req_vs, bus.req_offset, bus.req_groupIndex,
                         bus.req_readSource, bus.req_instructionIndex};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic pick(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic clear_model();
        pipe.delete();
        exp_out.delete();
        in_flight      = 0;
        m_k            = 0;
        m_count        = 0;
        prev_last_fire = 0;
        prev_req_stall = 0;
        cyc_since_cmd  = 0;
    endtask

    // one clock: drive at negedge, sample 1 time unit later, fire at posedge
    task automatic cycle();
        bit          rf, of, sf;
        exp_out_t    e;
        logic [5:0]  kb;
        @(negedge clock);
        bus.req_ready = pick(rq_mode);
        bus.out_ready = pick(out_mode);
        if (pipe.size() > 0 && rsp_mode != 2) begin
            bus.rsp_valid = pick(rsp_mode);
            bus.rsp_data  = pipe[0];
        end else begin
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = $urandom();
        end
        #1;
        cyc_since_cmd++;
        check("done_timing", done, (m_count == 0) ? (cyc_since_cmd == 1) : prev_last_fire);
        check("credits", dut.credits, MAXO - in_flight);
        if (in_flight == MAXO) check("req_valid_no_credit", bus.req_valid, 1'b0);
        if (prev_req_stall) begin
            check("req_hold_valid", bus.req_valid, 1'b1);
            check("req_hold_fields", req_fields, prev_fields);
        end
        rf = bus.req_valid && bus.req_ready;
        of = bus.out_valid && bus.out_ready;
        sf = bus.rsp_valid && bus.rsp_ready;
        prev_last_fire = 0;
        if (rf) begin
            kb = 6'(m_k);
            check("req_in_range", m_k < m_count, 1'b1);
            check("req_fields", req_fields, {m_vs, kb[0], kb[4:1], m_rs, m_ii});
            e.data = $urandom();
            e.last = (m_k == m_count - 1);
            pipe.push_back(e.data);
            exp_out.push_back(e);
            m_k++;
            in_flight++;
        end
        if (of) begin
            if (exp_out.size() == 0) begin
                check("out_unexpected", 1'b1, 1'b0);
            end else begin
                e = exp_out.pop_front();
                check("out_data", bus.out_data, e.data);
                check("out_last", bus.out_last, e.last);
                prev_last_fire = e.last;
            end
            in_flight--;
        end
        if (sf || of) check("rsp_out_fire_match", sf, of);
        if (sf && pipe.size() > 0) void'(pipe.pop_front());
        prev_req_stall = bus.req_valid && !bus.req_ready;
        prev_fields    = req_fields;
        last_rf        = rf;
        last_of        = of;
    endtask

    task automatic send_cmd(input logic [4:0] vs, input int unsigned cnt,
                            input logic [3:0] rs, input logic [2:0] ii);
        @(negedge clock);
        bus.cmd_valid            = 1'b1;
        bus.cmd_vs               = vs;
        bus.cmd_count            = CNT_WIDTH'(cnt);
        bus.cmd_readSource       = rs;
        bus.cmd_instructionIndex = ii;
        bus.rsp_valid            = 1'b0;
        bus.req_ready            = 1'b0;
        bus.out_ready            = 1'b0;
        #1;
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        check("req_valid_idle", bus.req_valid, 1'b0);
        clear_model();
        m_count = (cnt > 32) ? 32 : cnt;
        m_vs = vs;
        m_rs = rs;
        m_ii = ii;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        check("cmd_ready_busy", bus.cmd_ready, 1'b0);
        check("req_valid_latency", bus.req_valid, m_count > 0);
    endtask

    task automatic run_to_done(input int unsigned bound);
        bit seen = 0;
        for (int unsigned i = 0; i < bound && !seen; i++) begin
            cycle();
            if (done) seen = 1;
        end
        check("done_seen", seen, 1'b1);
        check("req_total", m_k, m_count);
        check("out_all_consumed", exp_out.size(), 0);
        @(posedge clock);
        #1;
        check("done_one_cycle", done, 1'b0);
        check("cmd_ready_after_done", bus.cmd_ready, 1'b1);
    endtask

    task automatic run_until_reqs(input int unsigned target, input int unsigned bound);
        for (int unsigned i = 0; i < bound && m_k < target; i++) cycle();
        check("reqs_reached", m_k, target);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hDEAD_BEEF;
        bus.out_ready = 1'b1;
        #1;
        check("reset_cmd_ready", bus.cmd_ready, 1'b1);
        check("reset_req_valid", bus.req_valid, 1'b0);
        check("reset_rsp_ready", bus.rsp_ready, 1'b0);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_req_fields", req_fields, 17'd0);
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        #1;
        check("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        check("post_reset_credits", dut.credits, MAXO);
        check("post_reset_out_valid", bus.out_valid, 1'b0);
        check("post_reset_req_valid", bus.req_valid, 1'b0);
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{5'd3,  4,  4'd1,  3'd2, 1, 1, 1, 4};
        tbl[1] = '{5'd5,  1,  4'd15, 3'd7, 1, 1, 1, 1};
        tbl[2] = '{5'd7,  2,  4'd0,  3'd0, 0, 0, 0, 2};
        tbl[3] = '{5'd31, 32, 4'd10, 3'd5, 0, 0, 0, 32};
        tbl[4] = '{5'd1,  40, 4'd6,  3'd1, 0, 1, 0, 32};
        tbl[5] = '{5'd2,  0,  4'd3,  3'd3, 1, 1, 1, 0};
        tbl[6] = '{5'd9,  63, 4'd12, 3'd4, 0, 0, 1, 32};
        tbl[7] = '{5'd4,  8,  4'd9,  3'd6, 1, 0, 0, 8};
        tbl[8] = '{5'd20, 5,  4'd1,  3'd1, 0, 1, 1, 5};

        bus.cmd_valid            = 1'b0;
        bus.cmd_vs               = '0;
        bus.cmd_count            = '0;
        bus.cmd_readSource       = '0;
        bus.cmd_instructionIndex = '0;
        bus.req_ready            = 1'b0;
        bus.rsp_valid            = 1'b0;
        bus.rsp_data             = '0;
        bus.out_ready            = 1'b0;
        rq_mode = 1;
        out_mode = 1;
        rsp_mode = 1;
        clear_model();

        do_reset();

        for (int i = 0; i < 9; i++) begin
            rq_mode  = tbl[i].rq_mode;
            out_mode = tbl[i].out_mode;
            rsp_mode = tbl[i].rsp_mode;
            send_cmd(tbl[i].vs, tbl[i].count, tbl[i].rs, tbl[i].ii);
            run_to_done(800);
            check("tbl_req_count", m_k, tbl[i].exp_reqs);
        end

        // responses withheld: credits run out after four requests
        rq_mode = 1; out_mode = 1; rsp_mode = 2;
        send_cmd(5'd11, 8, 4'd2, 3'd1);
        repeat (12) cycle();
        check("no_rsp_req_count", m_k, 4);
        check("no_rsp_req_valid", bus.req_valid, 1'b0);
        rsp_mode = 1;
        run_to_done(200);

        // request and response fire together with two credits left
        rq_mode = 1; out_mode = 1; rsp_mode = 2;
        send_cmd(5'd6, 8, 4'd1, 3'd2);
        run_until_reqs(2, 10);
        rsp_mode = 1;
        cycle();
        check("same_cycle_both_fire", {last_rf, last_of}, 2'b11);
        @(posedge clock);
        #1;
        check("same_cycle_credits", dut.credits, 2);
        rq_mode = 0; out_mode = 0; rsp_mode = 0;
        run_to_done(300);

        // reset abandons a command mid-issue; a fresh command restarts at word 0
        rq_mode = 1; out_mode = 1; rsp_mode = 2;
        send_cmd(5'd13, 8, 4'd5, 3'd3);
        run_until_reqs(2, 10);
        do_reset();
        rq_mode = 1; out_mode = 1; rsp_mode = 1;
        send_cmd(5'd14, 3, 4'd7, 3'd0);
        run_to_done(100);

`ifdef VRF_READ_SEQ_PERF_EN
        do_reset();
        rq_mode = 2; out_mode = 1; rsp_mode = 2;
        send_cmd(5'd8, 16, 4'd0, 3'd0);
        repeat (10) cycle();
        @(posedge clock);
        #1;
        check("perf_stall", perf_stall, 16'd10);
        rq_mode = 0; rsp_mode = 0;
        run_to_done(800);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
